// File: rtl/i2c_slave_regs_pkg.sv
// rtl/i2c_slave_regs_pkg.sv - shared FSM encoding and byte-length constant
// Purpose: state enumeration and bit-count constant shared by the
//          I2C register responder and its bench.
package i2c_slv_pkg;

  localparam int BIT_CNT = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - I2C pad-side signal bundle
// Purpose: groups the open-drain I2C pad signals.
// Signals: scl_in/sda_in (pad levels into the responder),
//          sda_oe/sda_o (pad drive enable and value from the responder).
interface i2c_slave_regs_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  logic sda_o;

  modport slave  (input  scl_in, input  sda_in, output sda_oe, output sda_o);
  modport master (output scl_in, output sda_in, input  sda_oe, input  sda_o);
endinterface

// File: rtl/i2c_slave_regs_line_sync.sv
// rtl/i2c_slave_regs_line_sync.sv - scl/sda synchronizer, edge and START/STOP detect
// Purpose: brings the asynchronous pad lines into the clock domain.
// Ports: i_clk/i_rst (clock, sync active-high reset), i_scl/i_sda (raw pads),
//        o_sda (synchronized sda level), o_scl_rise/o_scl_fall (scl edges),
//        o_start/o_stop (bus conditions), all single-cycle pulses except o_sda.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  // All flops preset to 1 so reset looks like an idle bus and no edge fires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= i_sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign o_sda      = r_sda_s2;
  assign o_scl_rise =  r_scl_s2 & ~r_scl_d;
  assign o_scl_fall = ~r_scl_s2 &  r_scl_d;
  assign o_start    = r_scl_s2 &  r_sda_d & ~r_sda_s2;
  assign o_stop     = r_scl_s2 & ~r_sda_d &  r_sda_s2;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C responder exposing a small register file
// Purpose: I2C target at SLV_ADDR with an auto-incrementing register pointer,
//          plus a local read/write port into the same register file.
// Ports: wb_clk_i/wb_rst_i (clock, sync active-high reset), bus (I2C pads),
//        loc_addr/loc_we/loc_wdata/loc_rdata (local port),
//        wr_strb/wr_addr (I2C write notification), busy (addressed transaction).
module i2c_slave_regs
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         NREG     = 16,
  localparam int        AW       = $clog2(NREG)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  i2c_slave_regs_if.slave      bus,
  input  logic [AW-1:0]        loc_addr,
  input  logic                 loc_we,
  input  logic [7:0]           loc_wdata,
  output logic [7:0]           loc_rdata,
  output logic                 wr_strb,
  output logic [AW-1:0]        wr_addr,
  output logic                 busy
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_scl      (bus.scl_in),
    .i_sda      (bus.sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_rw, w_rw_nxt;
  logic          r_mack, w_mack_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_i2c_we;
  logic          r_wr_strb;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_loc_rdata;
  logic [7:0]    r_regs [NREG];

  logic [AW-1:0] w_ptr_inc;
  logic [7:0]    w_rd_cur, w_rd_nxt;
  logic          w_byte_done;

  assign w_ptr_inc   = r_ptr + 1'b1;
  assign w_rd_cur    = r_regs[r_ptr];
  assign w_rd_nxt    = r_regs[w_ptr_inc];
  assign w_byte_done = (r_bitcnt == 4'(BIT_CNT));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_rw     <= 1'b0;
      r_mack   <= 1'b1;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_rw     <= w_rw_nxt;
      r_mack   <= w_mack_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Bits are counted on scl rising edges; every decision that can move sda
  // is taken on the following falling edge so sda only changes while scl is low.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_rw_nxt     = r_rw;
    w_mack_nxt   = r_mack;
    w_ptr_nxt    = r_ptr;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_i2c_we     = 1'b0;

    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && w_byte_done) begin
            w_bitcnt_nxt = '0;
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == SLV_ADDR) begin
                w_state_nxt  = ST_ADDR_ACK;
                w_rw_nxt     = r_shift[0];
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_WAIT;
              end
            end else if (r_state == ST_PTR) begin
              w_ptr_nxt    = r_shift[AW-1:0];
              w_state_nxt  = ST_PTR_ACK;
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_i2c_we     = 1'b1;
              w_ptr_nxt    = w_ptr_inc;
              w_state_nxt  = ST_WDATA_ACK;
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_nxt  = ST_RDATA;
              w_shift_nxt  = w_rd_cur;
              w_sda_oe_nxt = ~w_rd_cur[7];
            end else begin
              w_state_nxt  = ST_PTR;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_WDATA;
            w_sda_oe_nxt = 1'b0;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (w_byte_done) begin
              w_state_nxt  = ST_RDATA_ACK;
              w_bitcnt_nxt = '0;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = w_rd_nxt;
              w_sda_oe_nxt = ~w_rd_nxt[7];
              w_state_nxt  = ST_RDATA;
            end else begin
              w_state_nxt  = ST_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Local write goes first so a same-index I2C write in the same cycle overrides it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_wr_strb   <= 1'b0;
      r_wr_addr   <= '0;
      r_loc_rdata <= '0;
    end else begin
      if (loc_we) r_regs[loc_addr] <= loc_wdata;
      if (w_i2c_we) r_regs[r_ptr] <= r_shift;
      r_wr_strb   <= w_i2c_we;
      r_wr_addr   <= r_ptr;
      r_loc_rdata <= r_regs[loc_addr];
    end
  end

  assign bus.sda_oe = r_sda_oe;
  assign bus.sda_o  = 1'b0;
  assign loc_rdata  = r_loc_rdata;
  assign wr_strb    = r_wr_strb;
  assign wr_addr    = r_wr_addr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - directed scoreboard bench for i2c_slave_regs
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] loc_addr = '0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_wdata = '0;
  logic [7:0] loc_rdata;
  logic       wr_strb;
  logic [3:0] wr_addr;
  logic       busy;
  logic       w_sda_line;

  i2c_slave_regs_if bus ();

  assign w_sda_line = m_sda & ~bus.sda_oe;
  assign bus.scl_in = m_scl;
  assign bus.sda_in = w_sda_line;

  i2c_slave_regs #(.SLV_ADDR(7'h50), .NREG(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .loc_addr  (loc_addr),
    .loc_we    (loc_we),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .wr_strb   (wr_strb),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_strb[$];
  logic [7:0] strb_log[$];
  int         strb_rd = 0;
  int         oe_cnt = 0;
  int         oe_before = 0;
  int         n_asrt = 0;
  int         n_fail = 0;
  logic [7:0] rd;

  always @(negedge clk) begin
    if (wr_strb) strb_log.push_back(8'(wr_addr));
    if (bus.sda_oe === 1'b1) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_asrt++;
      n_fail++;
      $error("FAIL sb_empty: observed %h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic check_strbs();
    logic [7:0] e;
    chk("strb_count", 8'(strb_log.size() - strb_rd), 8'(exp_strb.size()));
    while (exp_strb.size() > 0) begin
      e = exp_strb.pop_front();
      if (strb_rd < strb_log.size()) chk("wr_addr", strb_log[strb_rd], e);
      strb_rd++;
    end
    strb_rd = strb_log.size();
  endtask

  task automatic qw();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b0; qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b1; qw();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; qw();
      m_scl = 1'b1; qw(); qw();
      m_scl = 1'b0; qw();
    end
  endtask

  task automatic get_ack(output logic a);
    m_sda = 1'b1; qw();
    m_scl = 1'b1; qw();
    a = w_sda_line; qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    sb_push(tag, {7'b0, exp_ack});
    send_bits(b, 8);
    get_ack(a);
    sb_check({7'b0, a});
  endtask

  // Last bit's scl fall lands at negedge t0; the DUT acts on it at the
  // third following posedge, so loc_we spans exactly that write cycle.
  task automatic send_collide(input logic [7:0] b, input logic [3:0] la,
                              input logic [7:0] lv, input string tag);
    logic a;
    sb_push(tag, 8'h00);
    send_bits(b, 7);
    m_sda = b[0]; qw();
    m_scl = 1'b1; qw(); qw();
    m_scl = 1'b0;
    loc_addr = la; loc_wdata = lv; loc_we = 1'b1;
    repeat (3) @(negedge clk);
    loc_we = 1'b0;
    repeat (5) @(negedge clk);
    get_ack(a);
    sb_check({7'b0, a});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string tag);
    logic [7:0] d = '0;
    sb_push(tag, exp);
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      d = {d[6:0], w_sda_line}; qw();
      m_scl = 1'b0; qw();
    end
    m_sda = ~m_ack; qw();
    m_scl = 1'b1; qw(); qw();
    m_scl = 1'b0; qw();
    m_sda = 1'b1;
    sb_check(d);
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] v);
    @(negedge clk);
    loc_addr = a; loc_wdata = v; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic chk_reg(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    loc_addr = a;
    @(negedge clk);
    chk(tag, loc_rdata, exp);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", 8'(bus.sda_oe), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_wr_strb", 8'(wr_strb), 8'h00);
    chk("rst_loc_rdata", loc_rdata, 8'h00);

    // Write 0x5A, 0xC3 starting at register 3.
    i2c_start();
    send_byte(8'hA0, 1'b0, "w1_addr_ack");
    chk("w1_busy", 8'(busy), 8'h01);
    send_byte(8'h03, 1'b0, "w1_ptr_ack");
    exp_strb.push_back(8'h03);
    send_byte(8'h5A, 1'b0, "w1_d0_ack");
    exp_strb.push_back(8'h04);
    send_byte(8'hC3, 1'b0, "w1_d1_ack");
    i2c_stop();
    chk("w1_busy_after_stop", 8'(busy), 8'h00);
    chk_reg(4'd3, 8'h5A, "w1_reg3");
    chk_reg(4'd4, 8'hC3, "w1_reg4");
    check_strbs();

    // Pointer 15, repeated start, read two bytes wrapping to register 0.
    loc_write(4'd15, 8'h96);
    loc_write(4'd0, 8'h3C);
    i2c_start();
    send_byte(8'hA0, 1'b0, "r1_addr_ack");
    send_byte(8'h0F, 1'b0, "r1_ptr_ack");
    i2c_start();
    send_byte(8'hA1, 1'b0, "r1_raddr_ack");
    read_byte(8'h96, 1'b1, "r1_rd_reg15");
    read_byte(8'h3C, 1'b0, "r1_rd_reg0_wrap");
    chk("r1_wait_sda_oe", 8'(bus.sda_oe), 8'h00);
    chk("r1_wait_busy", 8'(busy), 8'h01);
    i2c_stop();
    chk("r1_busy_after_stop", 8'(busy), 8'h00);

    // Foreign address: no ACK, no drive, nothing written.
    oe_before = oe_cnt;
    i2c_start();
    send_byte(8'hB0, 1'b1, "na_addr_nack");
    chk("na_busy", 8'(busy), 8'h00);
    send_byte(8'h03, 1'b1, "na_byte_ignored");
    i2c_stop();
    chk("na_oe_cycles", 8'(oe_cnt - oe_before), 8'h00);
    chk_reg(4'd3, 8'h5A, "na_reg3");
    check_strbs();

    // STOP in the middle of a data byte.
    i2c_start();
    send_byte(8'hA0, 1'b0, "ms_addr_ack");
    send_byte(8'h05, 1'b0, "ms_ptr_ack");
    send_bits(8'hF0, 4);
    i2c_stop();
    chk("ms_sda_oe", 8'(bus.sda_oe), 8'h00);
    chk("ms_busy", 8'(busy), 8'h00);
    chk_reg(4'd5, 8'h00, "ms_reg5");
    check_strbs();

    // Local writes colliding with I2C writes: same index, then different index.
    i2c_start();
    send_byte(8'hA0, 1'b0, "co_addr_ack");
    send_byte(8'h04, 1'b0, "co_ptr_ack");
    exp_strb.push_back(8'h04);
    send_collide(8'h22, 4'd4, 8'h11, "co_same_ack");
    exp_strb.push_back(8'h05);
    send_collide(8'h33, 4'd9, 8'h99, "co_diff_ack");
    i2c_stop();
    chk_reg(4'd4, 8'h22, "co_reg4_i2c_wins");
    chk_reg(4'd5, 8'h33, "co_reg5");
    chk_reg(4'd9, 8'h99, "co_reg9_local");
    check_strbs();

    // Reset while the address ACK is being driven.
    i2c_start();
    send_bits(8'hA0, 8);
    m_sda = 1'b1; qw();
    chk("rs_ack_driven", 8'(bus.sda_oe), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_sda_oe", 8'(bus.sda_oe), 8'h00);
    m_scl = 1'b1; qw(); qw();
    m_scl = 1'b0; qw();
    i2c_stop();
    chk_reg(4'd3, 8'h00, "rs_reg3");
    chk_reg(4'd4, 8'h00, "rs_reg4");
    chk_reg(4'd9, 8'h00, "rs_reg9");

    // Normal traffic after reset, then a read from the persisted pointer.
    i2c_start();
    send_byte(8'hA0, 1'b0, "pr_addr_ack");
    send_byte(8'h07, 1'b0, "pr_ptr_ack");
    exp_strb.push_back(8'h07);
    send_byte(8'h77, 1'b0, "pr_d0_ack");
    exp_strb.push_back(8'h08);
    send_byte(8'h88, 1'b0, "pr_d1_ack");
    i2c_stop();
    check_strbs();
    i2c_start();
    send_byte(8'hA0, 1'b0, "pr_setptr_addr_ack");
    send_byte(8'h07, 1'b0, "pr_setptr_ack");
    i2c_stop();
    i2c_start();
    send_byte(8'hA1, 1'b0, "pr_raddr_ack");
    read_byte(8'h77, 1'b1, "pr_rd_reg7");
    read_byte(8'h88, 1'b0, "pr_rd_reg8");
    i2c_stop();
    chk_reg(4'd7, 8'h77, "pr_reg7");
    chk("sb_leftover", 8'(sb_q.size()), 8'h00);
    check_strbs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
